timer_cmp_irq: RTL and testbench
================================

TIMER_CMP_IRQ -- requirements
Module: timer_cmp_irq

Interface
REQ-001 Parameter TW, default 16: width of the timer value, compare, period and data registers.
REQ-002 Parameter OVW, default 8: width of the overrun counter.
REQ-003 clk  in  1  system clock; the same clock that registers the upstream timer output.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 tval  in  TW  free-running timer value from the upstream timer stage, synchronous to clk.
REQ-006 wr_en  in  1  register write strobe, one clk cycle per write.
REQ-007 addr  in  2  register select: 0=CTRL, 1=CMP, 2=PERIOD, 3=STATUS (read-only).
REQ-008 wr_data  in  TW  write data.
REQ-009 rd_data  out  TW  combinational read of the register selected by addr.
REQ-010 irq  out  1  level interrupt request, registered.
REQ-011 irq_ack  in  1  single-cycle interrupt acknowledge.

Function
REQ-012 CTRL bits SHALL be: [0] EN (run), [1] PER (periodic), [2] IE (interrupt enable); all other bits read 0.
REQ-013 tick SHALL be 1 in any cycle where tval differs from tval_q, the registered copy of tval from the previous cycle.
REQ-014 match SHALL be tick AND (tval == target) AND state != IDLE; target is an internal register loaded from CMP.
REQ-015 FSM states: IDLE, ARMED, FIRED.
REQ-016 IDLE -> ARMED on a write of CTRL with EN=1; target <= CMP value at that same edge.
REQ-017 ARMED -> FIRED on match.
REQ-018 FIRED -> ARMED on irq_ack when no match occurs in the same cycle.
REQ-019 Any state -> IDLE on a CTRL write with EN=0; pending, irq and target are cleared.
REQ-020 On match with PER=1: target <= target + PERIOD, modulo 2^TW, and EN stays 1.
REQ-021 On match with PER=0: EN <= 0. The state still goes to FIRED and returns to IDLE on irq_ack.
REQ-022 irq SHALL equal (state == FIRED) AND IE, registered, one cycle after the match edge.
REQ-023 A match and irq_ack in the same cycle: the match wins; the state stays FIRED and irq stays 1.
REQ-024 A CMP write while ARMED updates CMP only. target changes only on an EN rising write or a periodic reload.
REQ-025 A write and a match in the same cycle: the match uses the pre-write values, and the write takes effect next cycle.
REQ-026 irq_ack while IDLE or ARMED SHALL be ignored.
REQ-027 STATUS SHALL read {overrun count (if compiled in), state[1:0]}, with state in the low bits.

Reset
REQ-028 On rst, all of the following SHALL be 0 and the FSM SHALL be in IDLE: CTRL, CMP, PERIOD, target, tval_q, irq, overrun counter.
REQ-029 The first tval value after reset deassertion SHALL NOT produce a tick unless it differs from 0.

Configuration
REQ-030 With TIMER_OVERRUN_CNT_EN defined, an OVW-bit counter SHALL be present:
- Increments on each match while the FSM is already FIRED.
- Saturates at all-ones.
- Clears on any STATUS-address write.
- Readable in STATUS[OVW+1:2].
REQ-031 Without TIMER_OVERRUN_CNT_EN, no counter SHALL exist, STATUS[TW-1:2] SHALL read 0, and a STATUS write SHALL be a no-op.

Structure
REQ-032 The shared package SHALL hold:
- The state enum.
- The register address constants.
- The CTRL bit-index constants.
REQ-033 Tick detection (tval_q register plus inequality compare) SHALL be a sub-module named tick_detect; the rest SHALL be flat.

Verification
REQ-034 One-shot:
- Stimulus: CMP=5, CTRL=EN|IE, then step tval 0..6.
- Required: irq=1 one cycle after tval=5; EN reads 0; irq_ack -> irq=0, state IDLE.
REQ-035 Periodic wrap:
- Stimulus: CMP=0xFFFE, PERIOD=4, CTRL=EN|PER|IE.
- Required: matches at tval=0xFFFE, then 0x0002, then 0x0006.
REQ-036 Ack collision:
- Stimulus: periodic with PERIOD=1, irq_ack in the same cycle as the next match.
- Required: irq stays 1 and state stays FIRED.
REQ-037 Overrun (macro defined):
- Stimulus: PERIOD=2, no ack for three further matches.
- Required: STATUS counter=3; after 300 unacked matches it reads 255.
REQ-038 Disable mid-run:
- Stimulus: CTRL write EN=0 while FIRED.
- Required: irq=0 next cycle, state IDLE, and the next equal tval does not fire.
REQ-039 Async reset:
- Stimulus: assert rst while FIRED.
- Required: irq=0 immediately, without waiting for a clk edge; all registers read 0.

Source files
------------

// File: rtl/timer_cmp_irq_pkg.sv
// Shared types and constants for the compare-match timer interrupt block:
// FSM state encoding, register addresses and CTRL bit positions.
package timer_cmp_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CMP    = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IE  = 2;

endpackage

// File: rtl/timer_cmp_irq_tick.sv
// Tick detector: flags every cycle in which the upstream timer value
// differs from the value it held on the previous clock.
module tick_detect #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] tval,
    output logic          tick
);

    logic [TW-1:0] tval_q;
    logic [TW-1:0] tval_d;

    always_comb begin
        tval_d = tval;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tval_q <= '0;
        end else begin
            tval_q <= tval_d;
        end
    end

    assign tick = (tval != tval_q);

endmodule

// File: rtl/timer_cmp_irq.sv
// Compare-match timer with one-shot/periodic modes and a level interrupt.
// Optional saturating overrun counter in STATUS when TIMER_OVERRUN_CNT_EN is defined.
module timer_cmp_irq
    import timer_cmp_irq_pkg::*;
#(
    parameter int TW  = 16,
    parameter int OVW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] tval,
    input  logic          wr_en,
    input  logic [1:0]    addr,
    input  logic [TW-1:0] wr_data,
    output logic [TW-1:0] rd_data,
    output logic          irq,
    input  logic          irq_ack
);

    logic          tick;
    logic          match;
    logic [2:0]    ctrl_q,   ctrl_d;
    logic [TW-1:0] cmp_q,    cmp_d;
    logic [TW-1:0] period_q, period_d;
    logic [TW-1:0] target_q, target_d;
    state_t        state_q,  state_d;
    logic          irq_q,    irq_d;
    logic [TW-1:0] status;

    tick_detect #(.TW(TW)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tval (tval),
        .tick (tick)
    );

    assign match = tick && (tval == target_q) && (state_q != ST_IDLE);

    // Match effects are computed from the current registers first; a register
    // write in the same cycle is layered on top and wins on the fields it owns.
    always_comb begin
        ctrl_d   = ctrl_q;
        cmp_d    = cmp_q;
        period_d = period_q;
        target_d = target_q;
        state_d  = state_q;

        if (match) begin
            state_d = ST_FIRED;
            if (ctrl_q[CTRL_PER]) begin
                target_d = target_q + period_q;
            end else begin
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end else if (irq_ack && (state_q == ST_FIRED)) begin
            state_d = ctrl_q[CTRL_EN] ? ST_ARMED : ST_IDLE;
        end

        if (wr_en) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_d = wr_data[2:0];
                    if (!wr_data[CTRL_EN]) begin
                        state_d  = ST_IDLE;
                        target_d = '0;
                    end else if (!ctrl_q[CTRL_EN]) begin
                        target_d = cmp_q;
                        if (state_d == ST_IDLE) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ADDR_CMP:    cmp_d    = wr_data;
                ADDR_PERIOD: period_d = wr_data;
                default: ;
            endcase
        end

        irq_d = (state_d == ST_FIRED) && ctrl_d[CTRL_IE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            cmp_q    <= '0;
            period_q <= '0;
            target_q <= '0;
            state_q  <= ST_IDLE;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            cmp_q    <= cmp_d;
            period_q <= period_d;
            target_q <= target_d;
            state_q  <= state_d;
            irq_q    <= irq_d;
        end
    end

`ifdef TIMER_OVERRUN_CNT_EN
    logic [OVW-1:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (match && (state_q == ST_FIRED) && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVW'(1);
        end
        if (wr_en && (addr == ADDR_STATUS)) begin
            ovr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign status = {{(TW-2){1'b0}}, state_q} | (TW'(ovr_q) << 2);
`else
    assign status = {{(TW-2){1'b0}}, state_q};
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CTRL:   rd_data = {{(TW-3){1'b0}}, ctrl_q};
            ADDR_CMP:    rd_data = cmp_q;
            ADDR_PERIOD: rd_data = period_q;
            default:     rd_data = status;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Directed bench for timer_cmp_irq: one-shot, periodic wrap, ack collision,
// overrun counter, mid-run disable and asynchronous reset.
module tb_timer_cmp_irq;

    logic        clk;
    logic        rst;
    logic [15:0] tval;
    logic        wr_en;
    logic [1:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        irq;
    logic        irq_ack;

    int checks;
    int errors;

    timer_cmp_irq #(.TW(16), .OVW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .tval    (tval),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .irq     (irq),
        .irq_ack (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v);
        addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic set_tval(input logic [15:0] v);
        tval = v;
        step();
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    logic [15:0] v;
    logic [15:0] t;
    logic        exp_irq;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        tval    = 16'h0;
        wr_en   = 1'b0;
        addr    = 2'd0;
        wr_data = 16'h0;
        irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_irq", irq, 0);
        rd(2'd0, v); check("rst_ctrl", v, 0);
        rd(2'd1, v); check("rst_cmp", v, 0);
        rd(2'd2, v); check("rst_period", v, 0);
        rd(2'd3, v); check("rst_status", v, 0);

        // One-shot compare at 5
        wr(2'd1, 16'd5);
        wr(2'd0, 16'h5);
        rd(2'd3, v); check("os_armed", v, 1);
        for (int i = 1; i <= 4; i++) set_tval(16'(i));
        check("os_irq_pre", irq, 0);
        set_tval(16'd5);
        check("os_irq_fire", irq, 1);
        rd(2'd3, v); check("os_fired", v, 2);
        rd(2'd0, v); check("os_en_clr", v, 16'h4);
        set_tval(16'd6);
        check("os_irq_hold", irq, 1);
        ack();
        check("os_irq_ack", irq, 0);
        rd(2'd3, v); check("os_idle", v, 0);

        // Periodic with wrap-around: matches at FFFE, 0002, 0006
        wr(2'd0, 16'h0);
        wr(2'd1, 16'hFFFE);
        wr(2'd2, 16'd4);
        wr(2'd0, 16'h7);
        t = 16'hFFFD;
        for (int i = 0; i < 11; i++) begin
            set_tval(t);
            exp_irq = (t == 16'hFFFE) || (t == 16'h0002) || (t == 16'h0006);
            check($sformatf("per_t%04h", t), irq, exp_irq);
            if (irq) begin
                ack();
                check($sformatf("per_ack%04h", t), irq, 0);
            end
            t = t + 16'd1;
        end
        rd(2'd3, v); check("per_armed", v, 1);

        // Ack colliding with the next match
        wr(2'd0, 16'h0);
        wr(2'd1, 16'd10);
        wr(2'd2, 16'd1);
        wr(2'd0, 16'h7);
        set_tval(16'd10);
        check("col_first", irq, 1);
        irq_ack = 1'b1;
        set_tval(16'd11);
        irq_ack = 1'b0;
        check("col_irq", irq, 1);
        rd(2'd3, v); check("col_state", v & 16'h3, 2);
        ack();
        check("col_ack_irq", irq, 0);
        rd(2'd3, v); check("col_ack_state", v & 16'h3, 1);

        // Disable while FIRED
        set_tval(16'd12);
        check("dis_fire", irq, 1);
        wr(2'd0, 16'h0);
        check("dis_irq", irq, 0);
        rd(2'd3, v); check("dis_idle", v & 16'h3, 0);
        set_tval(16'd13);
        check("dis_no_fire13", irq, 0);
        set_tval(16'd0);
        check("dis_no_fire0", irq, 0);
        rd(2'd3, v); check("dis_still_idle", v & 16'h3, 0);

        // Overrun counting (or its absence)
        wr(2'd3, 16'h0);
        wr(2'd1, 16'd20);
        wr(2'd2, 16'd2);
        wr(2'd0, 16'h7);
        set_tval(16'd20);
        check("ovr_fire", irq, 1);
        set_tval(16'd22);
        set_tval(16'd24);
        set_tval(16'd26);
`ifdef TIMER_OVERRUN_CNT_EN
        rd(2'd3, v); check("ovr_cnt3", v, 16'h000E);
        t = 16'd28;
        for (int i = 0; i < 297; i++) begin
            set_tval(t);
            t = t + 16'd2;
        end
        rd(2'd3, v); check("ovr_sat", v, 16'h03FE);
        wr(2'd3, 16'h0);
        rd(2'd3, v); check("ovr_clear", v, 16'h0002);
        set_tval(t);
        rd(2'd3, v); check("ovr_after_clr", v, 16'h0006);
`else
        rd(2'd3, v); check("ovr_absent", v, 16'h0002);
        wr(2'd3, 16'hFFFF);
        rd(2'd3, v); check("ovr_wr_noop", v, 16'h0002);
`endif
        check("ovr_irq", irq, 1);

        // Asynchronous reset while FIRED
        tval = 16'h0;
        rst  = 1'b1;
        #1;
        check("arst_irq", irq, 0);
        rd(2'd0, v); check("arst_ctrl", v, 0);
        rd(2'd1, v); check("arst_cmp", v, 0);
        rd(2'd2, v); check("arst_period", v, 0);
        rd(2'd3, v); check("arst_status", v, 0);
        step();
        rst = 1'b0;
        // tval held at 0 after reset must not tick, even against target 0
        wr(2'd0, 16'h5);
        set_tval(16'd0);
        check("post_rst_notick", irq, 0);
        rd(2'd3, v); check("post_rst_armed", v, 1);
        set_tval(16'd1);
        check("post_rst_t1", irq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
